// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline definitions for the EX/MEM register: datapath width default,
// JALR target mask, instruction-class encoding and the MEM control payload.
package ex_mem_reg_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam logic [31:0] JALR_MASK_DEF = 32'hFFFF_FFFE;
    localparam int unsigned RD_W          = 5;

    // Control-flow class of an instruction, shared with ID/EX and the hazard unit
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JAL    = 2'd2,
        CLS_JALR   = 2'd3
    } insn_class_e;

    // Control bits carried into the memory stage
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic halt;
    } ctrl_t;

    // Fold the class flags into the encoded class; JALR > JAL > branch if several are set
    function automatic insn_class_e insn_class(input logic is_branch,
                                               input logic is_jal,
                                               input logic is_jalr);
        insn_class_e cls;
        cls = CLS_NONE;
        if (is_jalr) begin
            cls = CLS_JALR;
        end else if (is_jal) begin
            cls = CLS_JAL;
        end else if (is_branch) begin
            cls = CLS_BRANCH;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ex_mem_reg_branch_target.sv
// Combinational branch/jump resolution: taken condition, fetch target and link value.
module ex_mem_reg_branch_target
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned     XLEN          = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC_MASK = XLEN'(JALR_MASK_DEF)
) (
    input  logic            valid,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            bcond,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            taken_c,
    output logic [XLEN-1:0] target_c,
    output logic            is_link_c,
    output logic [XLEN-1:0] link_c
);

    insn_class_e cls;
    logic        taken_raw;

    // Resolve the target and the unqualified taken condition from the class
    always_comb begin
        cls       = insn_class(is_branch, is_jal, is_jalr);
        taken_raw = 1'b0;
        target_c  = pc + imm;
        is_link_c = 1'b0;
        case (cls)
            CLS_BRANCH: taken_raw = bcond;
            CLS_JAL: begin
                taken_raw = 1'b1;
                is_link_c = 1'b1;
            end
            CLS_JALR: begin
                taken_raw = 1'b1;
                is_link_c = 1'b1;
                target_c  = alu_result & RESET_PC_MASK;
            end
            default: taken_raw = 1'b0;
        endcase
        taken_c = valid & taken_raw;
        link_c  = pc + XLEN'(4);
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with predict-not-taken branch resolution and a
// registered one-cycle fetch redirect. Supports stall (hold) and flush (bubble).
// Optional performance counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned     XLEN          = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC_MASK = XLEN'(JALR_MASK_DEF)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_alu_bcond,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_mem_to_reg,
    input  logic            ex_halt,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_mem_to_reg,
    output logic            mem_halt,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]     perf_branch_cnt,
    output logic [31:0]     perf_taken_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    logic            taken_c;
    logic [XLEN-1:0] target_c;
    logic            is_link_c;
    logic [XLEN-1:0] link_c;
    logic            capture_c;
    ctrl_t           mem_ctrl_q;

    ex_mem_reg_branch_target #(
        .XLEN          (XLEN),
        .RESET_PC_MASK (RESET_PC_MASK)
    ) u_branch_target (
        .valid      (ex_valid),
        .is_branch  (ex_is_branch),
        .is_jal     (ex_is_jal),
        .is_jalr    (ex_is_jalr),
        .bcond      (ex_alu_bcond),
        .pc         (ex_pc),
        .imm        (ex_imm),
        .alu_result (ex_alu_result),
        .taken_c    (taken_c),
        .target_c   (target_c),
        .is_link_c  (is_link_c),
        .link_c     (link_c)
    );

    assign capture_c = ~flush & ~stall;

    // Pipeline register: reset > flush > stall > capture; halt is sticky until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_ctrl_q     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (flush) begin
            mem_valid             <= 1'b0;
            mem_ctrl_q.reg_write  <= 1'b0;
            mem_ctrl_q.mem_read   <= 1'b0;
            mem_ctrl_q.mem_write  <= 1'b0;
            mem_ctrl_q.mem_to_reg <= 1'b0;
            redirect_valid        <= 1'b0;
        end else if (stall) begin
            redirect_valid <= 1'b0;
        end else begin
            mem_valid             <= ex_valid;
            mem_result            <= is_link_c ? link_c : ex_alu_result;
            mem_store_data        <= ex_rs2_data;
            mem_rd                <= ex_rd;
            mem_ctrl_q.reg_write  <= ex_valid & ex_reg_write;
            mem_ctrl_q.mem_read   <= ex_valid & ex_mem_read;
            mem_ctrl_q.mem_write  <= ex_valid & ex_mem_write;
            mem_ctrl_q.mem_to_reg <= ex_valid & ex_mem_to_reg;
            mem_ctrl_q.halt       <= mem_ctrl_q.halt | (ex_valid & ex_halt);
            redirect_valid        <= taken_c;
            if (taken_c) begin
                redirect_pc <= target_c;
            end
        end
    end

    assign mem_reg_write  = mem_ctrl_q.reg_write;
    assign mem_mem_read   = mem_ctrl_q.mem_read;
    assign mem_mem_write  = mem_ctrl_q.mem_write;
    assign mem_mem_to_reg = mem_ctrl_q.mem_to_reg;
    assign mem_halt       = mem_ctrl_q.halt;

`ifdef EX_MEM_PERF_EN
    // Event counters: hold on stall, count on capture or flush edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_branch_cnt <= '0;
            perf_taken_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (flush) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end else if (capture_c) begin
            if (ex_valid && ex_is_branch) begin
                perf_branch_cnt <= perf_branch_cnt + 32'd1;
            end
            if (taken_c) begin
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
            end
            if (!ex_valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`else
    // Capture qualifier only feeds the counters
    logic unused_capture;
    assign unused_capture = capture_c;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (counter checks when EX_MEM_PERF_EN is defined).
module tb_ex_mem_reg;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic        ex_alu_bcond;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_halt;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_mem_to_reg;
    logic        mem_halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_taken_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    ex_mem_reg dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_alu_bcond   (ex_alu_bcond),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs2_data    (ex_rs2_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_halt        (ex_halt),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_halt       (mem_halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_branch_cnt (perf_branch_cnt),
        .perf_taken_cnt  (perf_taken_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_alu_result = '0;
        ex_alu_bcond  = 1'b0;
        ex_is_branch  = 1'b0;
        ex_is_jal     = 1'b0;
        ex_is_jalr    = 1'b0;
        ex_pc         = '0;
        ex_imm        = '0;
        ex_rs2_data   = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_halt       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        clear_ex();
        #3;
        chk("rst_valid",    32'(mem_valid), 32'd0);
        chk("rst_result",   mem_result, 32'd0);
        chk("rst_regwr",    32'(mem_reg_write), 32'd0);
        chk("rst_halt",     32'(mem_halt), 32'd0);
        chk("rst_redir",    32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD x3 -> 5
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0005; ex_rd = 5'd3; ex_reg_write = 1'b1;
        tick();
        chk("add_result", mem_result, 32'h5);
        chk("add_rd",     32'(mem_rd), 32'd3);
        chk("add_regwr",  32'(mem_reg_write), 32'd1);
        chk("add_valid",  32'(mem_valid), 32'd1);
        chk("add_redir",  32'(redirect_valid), 32'd0);

        // Taken branch backwards
        clear_ex();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_alu_bcond = 1'b1;
        ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0; ex_alu_result = 32'h1;
        tick();
        chk("br_redir",    32'(redirect_valid), 32'd1);
        chk("br_redir_pc", redirect_pc, 32'hF0);
        chk("br_regwr",    32'(mem_reg_write), 32'd0);

        // Invalid slot with control bits set: gated off, redirect drops, pc held
        clear_ex();
        ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h500;
        tick();
        chk("inv_redir",    32'(redirect_valid), 32'd0);
        chk("inv_redir_pc", redirect_pc, 32'hF0);
        chk("inv_valid",    32'(mem_valid), 32'd0);
        chk("inv_regwr",    32'(mem_reg_write), 32'd0);
        chk("inv_memwr",    32'(mem_mem_write), 32'd0);

        // Not-taken branch
        clear_ex();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_alu_bcond = 1'b0; ex_pc = 32'h300; ex_imm = 32'h20;
        tick();
        chk("nt_redir",    32'(redirect_valid), 32'd0);
        chk("nt_redir_pc", redirect_pc, 32'hF0);

        // JALR: target masked, link = pc+4
        clear_ex();
        ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_alu_result = 32'h203; ex_pc = 32'h40;
        ex_imm = 32'h1000; ex_rd = 5'd1; ex_reg_write = 1'b1;
        tick();
        chk("jalr_redir",    32'(redirect_valid), 32'd1);
        chk("jalr_redir_pc", redirect_pc, 32'h202);
        chk("jalr_result",   mem_result, 32'h44);

        // JAL then three stall cycles
        clear_ex();
        ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h200; ex_imm = 32'h10;
        ex_rd = 5'd1; ex_reg_write = 1'b1; ex_rs2_data = 32'hAAAA; ex_alu_result = 32'h77;
        tick();
        chk("jal_redir",    32'(redirect_valid), 32'd1);
        chk("jal_redir_pc", redirect_pc, 32'h210);
        chk("jal_result",   mem_result, 32'h204);
        stall = 1'b1;
        ex_pc = 32'h900; ex_rd = 5'd9; ex_alu_result = 32'h99; ex_rs2_data = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_redir",  32'(redirect_valid), 32'd0);
            chk("stall_result", mem_result, 32'h204);
            chk("stall_rd",     32'(mem_rd), 32'd1);
            chk("stall_regwr",  32'(mem_reg_write), 32'd1);
            chk("stall_sdata",  mem_store_data, 32'hAAAA);
            chk("stall_pc",     redirect_pc, 32'h210);
        end
        flush = 1'b1;
        tick();
        chk("fs_valid", 32'(mem_valid), 32'd0);
        chk("fs_regwr", 32'(mem_reg_write), 32'd0);
        chk("fs_redir", 32'(redirect_valid), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // PC wrap on JAL
        clear_ex();
        ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h8;
        tick();
        chk("wrap_redir_pc", redirect_pc, 32'h4);
        chk("wrap_result",   mem_result, 32'h0);
        chk("wrap_redir",    32'(redirect_valid), 32'd1);

        // Flush alone over a taken branch: no redirect, bubble
        clear_ex();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_alu_bcond = 1'b1; ex_pc = 32'h40; ex_imm = 32'h40;
        ex_mem_read = 1'b1;
        flush = 1'b1;
        tick();
        chk("fl_redir",    32'(redirect_valid), 32'd0);
        chk("fl_valid",    32'(mem_valid), 32'd0);
        chk("fl_memrd",    32'(mem_mem_read), 32'd0);
        chk("fl_redir_pc", redirect_pc, 32'h4);
        flush = 1'b0;

        // Store with load-style control set
        clear_ex();
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_rs2_data = 32'hDEAD_BEEF; ex_alu_result = 32'h1000;
        ex_mem_to_reg = 1'b1;
        tick();
        chk("st_memwr", 32'(mem_mem_write), 32'd1);
        chk("st_sdata", mem_store_data, 32'hDEAD_BEEF);
        chk("st_m2r",   32'(mem_mem_to_reg), 32'd1);
        chk("st_addr",  mem_result, 32'h1000);

        // Halt captured, then stays set across a later instruction
        clear_ex();
        ex_valid = 1'b1; ex_halt = 1'b1;
        tick();
        chk("halt_set", 32'(mem_halt), 32'd1);
        clear_ex();
        ex_valid = 1'b1; ex_alu_result = 32'h12;
        tick();
        chk("halt_sticky", 32'(mem_halt), 32'd1);
        chk("halt_result", mem_result, 32'h12);

        // Asynchronous reset mid-stream
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",  32'(mem_valid), 32'd0);
        chk("arst_halt",   32'(mem_halt), 32'd0);
        chk("arst_result", mem_result, 32'd0);
        chk("arst_pc",     redirect_pc, 32'd0);
`ifdef EX_MEM_PERF_EN
        chk("arst_pbr",  perf_branch_cnt, 32'd0);
        chk("arst_ptk",  perf_taken_cnt, 32'd0);
        chk("arst_pbub", perf_bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

`ifdef EX_MEM_PERF_EN
        clear_ex();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_alu_bcond = 1'b1; ex_pc = 32'h10; ex_imm = 32'h4;
        tick();
        chk("perf_br",  perf_branch_cnt, 32'd1);
        chk("perf_tk",  perf_taken_cnt, 32'd1);
        chk("perf_bub", perf_bubble_cnt, 32'd0);
        stall = 1'b1;
        tick();
        chk("perf_hold_br", perf_branch_cnt, 32'd1);
        flush = 1'b1;
        tick();
        chk("perf_fl_bub", perf_bubble_cnt, 32'd1);
        stall = 1'b0;
        flush = 1'b0;
        clear_ex();
        tick();
        chk("perf_inv_bub", perf_bubble_cnt, 32'd2);
`endif

        // Fresh capture after reset
        clear_ex();
        ex_valid = 1'b1; ex_alu_result = 32'h5; ex_rd = 5'd3; ex_reg_write = 1'b1;
        tick();
        chk("post_result", mem_result, 32'h5);
        chk("post_halt",   32'(mem_halt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
